// File: rtl/fsm_control_conmutador.sv
// -----------------------------------------------------------------------------
// fsm_control_conmutador
//
// Purpose:
//    Control state machine for a 4-in/4-out FIFO switch. It steps the switch
//    through RESET -> INIT -> IDLE/ACTIVE, and it can enter an absorbing ERROR
//    state. In INIT it latches the almost-full/almost-empty thresholds and
//    drives them back to the FIFOs. An overflow error records the offending
//    FIFO bits, which hold until reset.
//
// Ports:
//    i_clk              system clock, rising edge
//    i_reset            asynchronous active-low reset (0 = in reset)
//    i_init             request to (re)enter INIT and program thresholds
//    i_umbral_alto_in   almost-full threshold to program
//    i_umbral_bajo_in   almost-empty threshold to program
//    i_empty_fifos      per-FIFO empty flags (bits 0-3 in, 4-7 out; 1 = empty)
//    i_overflow_fifos   per-FIFO overflow pulses
//    o_state            current state encoding
//    o_idle_out         high while in IDLE
//    o_active_out       high while in ACTIVE
//    o_error_out        high while in ERROR
//    o_error_src        overflow bits captured on ERROR entry (0 = threshold error)
//    o_umbral_alto_out  active almost-full threshold
//    o_umbral_bajo_out  active almost-empty threshold
// -----------------------------------------------------------------------------
module fsm_control_conmutador #(
   parameter int          NUM_FIFOS = 8,
   parameter int          THR_WIDTH = 3,
   parameter int unsigned DEF_ALTO  = 6,
   parameter int unsigned DEF_BAJO  = 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_init,
   input  logic [THR_WIDTH-1:0] i_umbral_alto_in,
   input  logic [THR_WIDTH-1:0] i_umbral_bajo_in,
   input  logic [NUM_FIFOS-1:0] i_empty_fifos,
   input  logic [NUM_FIFOS-1:0] i_overflow_fifos,
   output logic [2:0]           o_state,
   output logic                 o_idle_out,
   output logic                 o_active_out,
   output logic                 o_error_out,
   output logic [NUM_FIFOS-1:0] o_error_src,
   output logic [THR_WIDTH-1:0] o_umbral_alto_out,
   output logic [THR_WIDTH-1:0] o_umbral_bajo_out
);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   localparam logic [THR_WIDTH-1:0] C_DEF_ALTO = THR_WIDTH'(DEF_ALTO);
   localparam logic [THR_WIDTH-1:0] C_DEF_BAJO = THR_WIDTH'(DEF_BAJO);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [NUM_FIFOS-1:0]   r_error_src;
   logic [THR_WIDTH-1:0]   r_umbral_alto;
   logic [THR_WIDTH-1:0]   r_umbral_bajo;

   logic                   w_overflow;
   logic                   w_thr_valid;
   logic                   w_all_empty;
   logic                   w_load_thr;
   logic                   w_enter_error;

   assign w_overflow  = |i_overflow_fifos;
   // A usable window needs the almost-empty level strictly below almost-full.
   assign w_thr_valid = (i_umbral_bajo_in < i_umbral_alto_in);
   assign w_all_empty = &i_empty_fifos;

   // Overflow wins over threshold loading in INIT.
   assign w_load_thr    = (r_state == ST_INIT) && !w_overflow && w_thr_valid;
   assign w_enter_error = (r_state != ST_ERROR) && (w_state_next == ST_ERROR);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic: overflow > init > empty status
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next = ST_RESET;
      case (r_state)
         ST_RESET: begin
            w_state_next = ST_INIT;
         end
         ST_INIT: begin
            if (w_overflow || !w_thr_valid) begin
               w_state_next = ST_ERROR;
            end else if (i_init) begin
               w_state_next = ST_INIT;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (w_overflow) begin
               w_state_next = ST_ERROR;
            end else if (i_init) begin
               w_state_next = ST_INIT;
            end else if (!w_all_empty) begin
               w_state_next = ST_ACTIVE;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (w_overflow) begin
               w_state_next = ST_ERROR;
            end else if (i_init) begin
               w_state_next = ST_INIT;
            end else if (w_all_empty) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_ACTIVE;
            end
         end
         ST_ERROR: begin
            w_state_next = ST_ERROR;
         end
         default: begin
            // Unused encodings recover through RESET.
            w_state_next = ST_RESET;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Thresholds and error source
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_umbral_alto <= C_DEF_ALTO;
         r_umbral_bajo <= C_DEF_BAJO;
         r_error_src   <= '0;
      end else begin
         if (w_load_thr) begin
            r_umbral_alto <= i_umbral_alto_in;
            r_umbral_bajo <= i_umbral_bajo_in;
         end
         // A threshold error has no overflow bits set, so the capture
         // naturally records zero for it.
         if (w_enter_error) begin
            r_error_src <= i_overflow_fifos;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output decode (from registers only, no input-to-output path)
   // -------------------------------------------------------------------------
   always_comb begin
      o_state           = r_state;
      o_idle_out        = (r_state == ST_IDLE);
      o_active_out      = (r_state == ST_ACTIVE);
      o_error_out       = (r_state == ST_ERROR);
      o_error_src       = r_error_src;
      o_umbral_alto_out = r_umbral_alto;
      o_umbral_bajo_out = r_umbral_bajo;
   end

endmodule

// File: tb/tb_fsm_control_conmutador.sv
module tb_fsm_control_conmutador;

   localparam int S_RESET  = 0;
   localparam int S_INIT   = 1;
   localparam int S_IDLE   = 2;
   localparam int S_ACTIVE = 3;
   localparam int S_ERROR  = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [2:0] alto_in;
   logic [2:0] bajo_in;
   logic [7:0] empty;
   logic [7:0] ovf;

   logic [2:0] state;
   logic       idle_o;
   logic       active_o;
   logic       error_o;
   logic [7:0] src;
   logic [2:0] alto_o;
   logic [2:0] bajo_o;

   int total = 0;
   int bad   = 0;

   // reference model
   int m_st;
   int m_a;
   int m_b;
   int m_src;

   always #5 clk = ~clk;

   fsm_control_conmutador dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_init            (init),
      .i_umbral_alto_in  (alto_in),
      .i_umbral_bajo_in  (bajo_in),
      .i_empty_fifos     (empty),
      .i_overflow_fifos  (ovf),
      .o_state           (state),
      .o_idle_out        (idle_o),
      .o_active_out      (active_o),
      .o_error_out       (error_o),
      .o_error_src       (src),
      .o_umbral_alto_out (alto_o),
      .o_umbral_bajo_out (bajo_o)
   );

   typedef struct {
      logic       init;
      logic [2:0] alto;
      logic [2:0] bajo;
      logic [7:0] empty;
      logic [7:0] ovf;
      int         st;
      int         a;
      int         b;
      int         s;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input int st, input int a, input int b, input int s);
      chk({tag, ".state"},  32'(state),    32'(st));
      chk({tag, ".idle"},   32'(idle_o),   32'(st == S_IDLE));
      chk({tag, ".active"}, 32'(active_o), 32'(st == S_ACTIVE));
      chk({tag, ".error"},  32'(error_o),  32'(st == S_ERROR));
      chk({tag, ".src"},    32'(src),      32'(s));
      chk({tag, ".alto"},   32'(alto_o),   32'(a));
      chk({tag, ".bajo"},   32'(bajo_o),   32'(b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      m_st  = S_RESET;
      m_a   = 6;
      m_b   = 1;
      m_src = 0;
   endfunction

   function automatic void model_error(input int bits);
      m_st  = S_ERROR;
      m_src = bits;
   endfunction

   // Behaviour at one rising edge, given the inputs present at that edge.
   function automatic void model_edge();
      if (!reset) begin
         model_reset();
         return;
      end
      case (m_st)
         S_RESET: m_st = S_INIT;
         S_INIT: begin
            if (ovf != 0)                     model_error(int'(ovf));
            else if (int'(bajo_in) >= int'(alto_in)) model_error(0);
            else begin
               m_a  = int'(alto_in);
               m_b  = int'(bajo_in);
               m_st = init ? S_INIT : S_IDLE;
            end
         end
         S_IDLE, S_ACTIVE: begin
            if (ovf != 0)        model_error(int'(ovf));
            else if (init)       m_st = S_INIT;
            else                 m_st = (empty == 8'hFF) ? S_IDLE : S_ACTIVE;
         end
         S_ERROR: ;
         default: m_st = S_RESET;
      endcase
   endfunction

   initial begin
      // {init, alto, bajo, empty, ovf} -> {state, alto_out, bajo_out, src}
      vecs[0] = '{1'b1, 3'd5, 3'd2, 8'hFF, 8'h00, S_INIT,   6, 1, 0};
      vecs[1] = '{1'b1, 3'd5, 3'd2, 8'hFF, 8'h00, S_INIT,   5, 2, 0};
      vecs[2] = '{1'b0, 3'd5, 3'd2, 8'hFF, 8'h00, S_IDLE,   5, 2, 0};
      vecs[3] = '{1'b0, 3'd5, 3'd2, 8'hEF, 8'h00, S_ACTIVE, 5, 2, 0};
      vecs[4] = '{1'b0, 3'd5, 3'd2, 8'hFF, 8'h00, S_IDLE,   5, 2, 0};
      vecs[5] = '{1'b0, 3'd0, 3'd7, 8'h7F, 8'h00, S_ACTIVE, 5, 2, 0};
      vecs[6] = '{1'b0, 3'd5, 3'd2, 8'hFE, 8'h00, S_ACTIVE, 5, 2, 0};
      vecs[7] = '{1'b1, 3'd5, 3'd2, 8'hFE, 8'h04, S_ERROR,  5, 2, 4};
      vecs[8] = '{1'b1, 3'd5, 3'd2, 8'h00, 8'h00, S_ERROR,  5, 2, 4};
      vecs[9] = '{1'b0, 3'd5, 3'd2, 8'hFF, 8'hFF, S_ERROR,  5, 2, 4};

      // ---- reset and bring-up ----
      reset = 1'b0; init = 1'b0; alto_in = 3'd6; bajo_in = 3'd1;
      empty = 8'hFF; ovf = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("rst_hold", S_RESET, 6, 1, 0);
      end
      reset = 1'b1;
      tick();
      check_all("rel1", S_INIT, 6, 1, 0);
      $display("bringup: state=%0d alto=%0d bajo=%0d", state, alto_o, bajo_o);
      tick();
      check_all("rel2", S_IDLE, 6, 1, 0);
      $display("bringup: state=%0d alto=%0d bajo=%0d", state, alto_o, bajo_o);

      // ---- table-driven vectors ----
      for (int v = 0; v < 10; v++) begin
         init = vecs[v].init; alto_in = vecs[v].alto; bajo_in = vecs[v].bajo;
         empty = vecs[v].empty; ovf = vecs[v].ovf;
         tick();
         check_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].a, vecs[v].b, vecs[v].s);
         $display("vec %0d: state=%0d alto=%0d bajo=%0d src=%02h", v, state, alto_o, bajo_o, src);
      end

      // ERROR is absorbing with init held
      init = 1'b1; ovf = 8'h00; empty = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_all("err_hold", S_ERROR, 5, 2, 4);
      end
      $display("err_hold: state=%0d src=%02h", state, src);

      // ---- threshold error (equal values) keeps previous thresholds ----
      reset = 1'b0; #1;
      check_all("async_rst_a", S_RESET, 6, 1, 0);
      reset = 1'b1; init = 1'b1; alto_in = 3'd5; bajo_in = 3'd2; empty = 8'hFF;
      tick();
      check_all("thr_a1", S_INIT, 6, 1, 0);
      tick();
      check_all("thr_a2", S_INIT, 5, 2, 0);
      alto_in = 3'd3; bajo_in = 3'd3;
      tick();
      check_all("thr_eq", S_ERROR, 5, 2, 0);
      $display("thr_eq: state=%0d src=%02h alto=%0d bajo=%0d", state, src, alto_o, bajo_o);

      // ---- threshold error (bajo > alto) ----
      reset = 1'b0; #1; reset = 1'b1;
      init = 1'b0; alto_in = 3'd2; bajo_in = 3'd7;
      tick();
      check_all("thr_b1", S_INIT, 6, 1, 0);
      tick();
      check_all("thr_gt", S_ERROR, 6, 1, 0);
      $display("thr_gt: state=%0d src=%02h", state, src);

      // ---- overflow in INIT beats a valid threshold load ----
      reset = 1'b0; #1; reset = 1'b1;
      alto_in = 3'd4; bajo_in = 3'd1; ovf = 8'h80;
      tick();
      check_all("ovf_i1", S_INIT, 6, 1, 0);
      tick();
      check_all("ovf_init", S_ERROR, 6, 1, 8'h80);
      $display("ovf_init: state=%0d src=%02h", state, src);

      // ---- async reset mid-cycle from ACTIVE ----
      reset = 1'b0; #1; reset = 1'b1;
      ovf = 8'h00; alto_in = 3'd5; bajo_in = 3'd2; init = 1'b0;
      tick();
      tick();
      check_all("act_idle", S_IDLE, 5, 2, 0);
      empty = 8'hEF;
      tick();
      check_all("act_act", S_ACTIVE, 5, 2, 0);
      #3 reset = 1'b0;
      #1;
      check_all("mid_rst", S_RESET, 6, 1, 0);
      $display("mid_rst: state=%0d alto=%0d bajo=%0d", state, alto_o, bajo_o);

      // ---- randomized run against the reference model ----
      model_reset();
      tick();
      for (int i = 0; i < 800; i++) begin
         reset = !(($urandom_range(0, 59) == 0) || (m_st == S_ERROR && $urandom_range(0, 5) == 0));
         init  = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) != 0) begin
            alto_in = 3'($urandom_range(1, 7));
            bajo_in = 3'($urandom_range(0, int'(alto_in) - 1));
         end else begin
            alto_in = 3'($urandom_range(0, 7));
            bajo_in = 3'($urandom_range(0, 7));
         end
         empty = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         ovf   = ($urandom_range(0, 39) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         if (!reset) model_reset();
         tick();
         model_edge();
         check_all($sformatf("rnd%0d", i), m_st, m_a, m_b, m_src);
         $display("rnd %0d: state=%0d exp=%0d alto=%0d bajo=%0d src=%02h", i, state, m_st, alto_o, bajo_o, src);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fsm_control_conmutador.md
Name: fsm_control_conmutador

Overview:
- Control state machine that sits directly downstream of the 4-in/4-out FIFO switch (4 input FIFOs, 4 output FIFOs) and consumes its 8-bit empty_fifos status vector.
- Sequences the switch through reset, initialisation, idle, active and error.
- Latches the almost-full/almost-empty thresholds programmed during initialisation and drives them back to the FIFOs.
- Flags overflow errors and holds them until reset.

Parameters:
NUM_FIFOS, 8, number of FIFO status bits monitored (4 input + 4 output)
THR_WIDTH, 3, width of each threshold; FIFO depth is 2**THR_WIDTH
DEF_ALTO, 6, almost-full threshold driven after reset
DEF_BAJO, 1, almost-empty threshold driven after reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
init  input  1  request to (re)enter INIT and program thresholds
umbral_alto_in  input  THR_WIDTH  almost-full threshold to program
umbral_bajo_in  input  THR_WIDTH  almost-empty threshold to program
empty_fifos  input  NUM_FIFOS  per-FIFO empty flags from the switch; bit i = 1 means FIFO i is empty
overflow_fifos  input  NUM_FIFOS  per-FIFO overflow pulses (push while full)
state  output  3  current state encoding
idle_out  output  1  high while in IDLE
active_out  output  1  high while in ACTIVE
error_out  output  1  high while in ERROR
error_src  output  NUM_FIFOS  overflow bits captured on ERROR entry
umbral_alto_out  output  THR_WIDTH  active almost-full threshold
umbral_bajo_out  output  THR_WIDTH  active almost-empty threshold

Behaviour:
- Encoding: RESET=3'd0, INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3, ERROR=3'd4. Any other value goes to RESET on the next edge.
- All outputs are registered and change only on a clk rising edge or on reset assertion.
- idle_out, active_out and error_out are decoded from the state register and are valid in the same cycle as state.
- While reset=0, asynchronously and immediately:
  - state=RESET
  - idle_out=0, active_out=0, error_out=0
  - error_src=0
  - umbral_alto_out=DEF_ALTO, umbral_bajo_out=DEF_BAJO
- Transition priority in every non-RESET, non-ERROR state: overflow > init > empty status.
- RESET: on the first clk edge after reset is released, go to INIT unconditionally; init is ignored.
- INIT:
  - Each cycle, check umbral_bajo_in against umbral_alto_in.
  - If umbral_bajo_in < umbral_alto_in (valid): load both into the *_out registers at that edge.
  - If umbral_bajo_in >= umbral_alto_in: go to ERROR next cycle, do not load the thresholds, set error_src=0.
  - If the thresholds are valid and init=0: go to IDLE. Thresholds sampled on that same edge are the ones kept.
  - If the thresholds are valid and init=1: stay in INIT.
  - If |overflow_fifos=1: go to ERROR. This takes precedence over threshold loading.
- IDLE:
  - |overflow_fifos=1 -> ERROR.
  - Else init=1 -> INIT.
  - Else if any empty_fifos bit is 0 -> ACTIVE.
  - Else remain in IDLE.
- ACTIVE:
  - |overflow_fifos=1 -> ERROR.
  - Else init=1 -> INIT.
  - Else if empty_fifos is all ones -> IDLE.
  - Else remain in ACTIVE.
- ERROR entry from IDLE, ACTIVE or INIT:
  - On the entering edge, error_src <= overflow_fifos. For a threshold error, error_src <= 0.
  - error_src and the thresholds hold until reset.
- ERROR: absorbing. init, empty_fifos and overflow_fifos are all ignored; only reset=0 exits.
- Latency:
  - An input change is reflected in state and the flags exactly 1 cycle later.
  - There is no combinational path from any input to any output.
- Re-entering INIT from IDLE or ACTIVE keeps the previous thresholds until the first valid INIT cycle overwrites them.
- Reset asserted mid-operation, in any state, aborts immediately to RESET and restores the threshold defaults.
- empty_fifos bits 0-3 correspond to the input FIFOs and bits 4-7 to the output FIFOs. All 8 bits are treated identically.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with init=0 -> state=0 during reset; state=1 one cycle after release; state=2 the next cycle; umbral_alto_out=6, umbral_bajo_out=1 throughout, since INIT loads the input values only if they are valid and the bench holds inputs alto=6, bajo=1.
2. In INIT with init=1, alto_in=5, bajo_in=2, then drop init -> one cycle later state=IDLE, umbral_alto_out=5, umbral_bajo_out=2, idle_out=1.
3. From IDLE, set empty_fifos=8'hEF (FIFO4 not empty) -> next cycle state=ACTIVE, active_out=1. Then set empty_fifos=8'hFF -> next cycle state=IDLE.
4. In ACTIVE, pulse overflow_fifos=8'h04 for one cycle while init=1 -> next cycle state=ERROR, error_out=1, error_src=8'h04. State stays ERROR after the pulse ends and with init=1 held for 10 cycles.
5. In INIT, apply alto_in=3, bajo_in=3 -> next cycle state=ERROR, error_src=0, thresholds unchanged from their previous values.
6. Assert reset=0 asynchronously mid-cycle while in ACTIVE with thresholds 5/2 -> state=0 and thresholds 6/1 without waiting for a clk edge; error_src=0.
